// File: rtl/calc_cmd_arbiter_pkg.sv
// Shared types and constants for the calculator command arbiter.
package calc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int SEL_W = 4;

    function automatic int wdog_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/calc_cmd_arbiter_if.sv
// Requester and calculator command bus seen by calc_cmd_arbiter.
// The arbiter uses the slave modport; the requester/calculator side uses master.
interface calc_cmd_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int INBITS = 8,
    parameter int WIDTH  = 8
) ();
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]                      ReqValid;
    logic [NREQ-1:0]                      ReqRW;
    logic [NREQ-1:0]                      ReqKey;
    logic [NREQ*WIDTH-1:0]                ReqAddr;
    logic [NREQ*INBITS-1:0]               ReqInA;
    logic [NREQ*INBITS-1:0]               ReqInB;
    logic [NREQ*calc_arb_pkg::SEL_W-1:0]  ReqSel;
    logic [NREQ-1:0]                      ReqAck;
    logic [NREQ-1:0]                      ReqDone;
    logic [NREQ-1:0]                      ReqErr;

    logic                                 ValidCmd;
    logic                                 RW;
    logic                                 InputKey;
    logic [WIDTH-1:0]                     Addr;
    logic [INBITS-1:0]                    InA;
    logic [INBITS-1:0]                    InB;
    logic [calc_arb_pkg::SEL_W-1:0]       Sel;
    logic                                 CalcBusy;
    logic [GW-1:0]                        GrantId;
    logic                                 ArbBusy;

    modport slave (
        input  ReqValid, ReqRW, ReqKey, ReqAddr, ReqInA, ReqInB, ReqSel, CalcBusy,
        output ReqAck, ReqDone, ReqErr, ValidCmd, RW, InputKey, Addr, InA, InB, Sel,
               GrantId, ArbBusy
    );

    modport master (
        output ReqValid, ReqRW, ReqKey, ReqAddr, ReqInA, ReqInB, ReqSel, CalcBusy,
        input  ReqAck, ReqDone, ReqErr, ValidCmd, RW, InputKey, Addr, InA, InB, Sel,
               GrantId, ArbBusy
    );

endinterface

// File: rtl/calc_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_ptr,
    output logic            o_found,
    output logic [GW-1:0]   o_idx
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_ptr) + k) % NREQ;
            if (i_req[j]) begin
                o_found = 1'b1;
                o_idx   = GW'(j);
            end
        end
    end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Round-robin arbiter sharing one BinaryCalculator among NREQ requesters.
// Optional watchdog abort is built when CALC_ARB_WATCHDOG_EN is defined.
module calc_cmd_arbiter
    import calc_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int INBITS      = 8,
    parameter int WIDTH       = 8,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    calc_cmd_arbiter_if.slave bus
);

    localparam int GW = $clog2(NREQ);

    generate
        if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 2) begin : g_bad_cfg
            $error("calc_cmd_arbiter: NREQ must be 2..8 and WDOG_CYCLES >= 2");
        end
    endgenerate

    arb_state_e         r_state, w_state_nxt;
    logic [GW-1:0]      r_rr_ptr, r_grant, w_win;
    logic               w_found, w_grant_go, w_done_go;
    logic               r_valid_cmd, r_rw, r_key, r_arb_busy;
    logic [WIDTH-1:0]   r_addr;
    logic [INBITS-1:0]  r_ina, r_inb;
    logic [SEL_W-1:0]   r_sel;
    logic [NREQ-1:0]    r_ack, r_done;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
        .i_req   (bus.ReqValid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

`ifdef CALC_ARB_WATCHDOG_EN
    localparam int WDOG_W = wdog_cnt_w(WDOG_CYCLES);

    logic [WDOG_W-1:0]  r_wdog_cnt;
    logic [NREQ-1:0]    r_err;
    logic               w_wdog_hit;

    // ISSUE counts as the first elapsed cycle, so Err lands WDOG_CYCLES after ValidCmd.
    assign w_wdog_hit = ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) &&
                        ((r_wdog_cnt + 1'b1) == WDOG_W'(WDOG_CYCLES));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wdog_cnt <= '0;
            r_err      <= '0;
        end else begin
            if (w_grant_go)
                r_wdog_cnt <= '0;
            else if (r_state != IDLE)
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            r_err <= w_wdog_hit ? (NREQ'(1) << r_grant) : '0;
        end
    end

    assign bus.ReqErr = r_err;
`else
    assign bus.ReqErr = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_done_go   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !bus.CalcBusy) begin
                    w_state_nxt = ISSUE;
                    w_grant_go  = 1'b1;
                end
            end
            ISSUE:     w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (bus.CalcBusy) w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.CalcBusy) begin
                    w_state_nxt = IDLE;
                    w_done_go   = 1'b1;
                end
            end
            default:   w_state_nxt = IDLE;
        endcase
`ifdef CALC_ARB_WATCHDOG_EN
        if (w_wdog_hit) begin
            w_state_nxt = IDLE;
            w_done_go   = 1'b0;
        end
`endif
    end

    // Every output is a register loaded from next-state decisions, so pulses
    // appear in the cycle after the deciding edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_valid_cmd <= 1'b0;
            r_ack       <= '0;
            r_done      <= '0;
            r_arb_busy  <= 1'b0;
            r_rw        <= 1'b0;
            r_key       <= 1'b0;
            r_addr      <= '0;
            r_ina       <= '0;
            r_inb       <= '0;
            r_sel       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid_cmd <= w_grant_go;
            r_ack       <= w_grant_go ? (NREQ'(1) << w_win) : '0;
            r_done      <= w_done_go ? (NREQ'(1) << r_grant) : '0;
            r_arb_busy  <= (w_state_nxt != IDLE);
            if (w_grant_go) begin
                r_grant  <= w_win;
                r_rr_ptr <= (w_win == GW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                r_rw     <= bus.ReqRW[w_win];
                r_key    <= bus.ReqKey[w_win];
                r_addr   <= bus.ReqAddr[int'(w_win) * WIDTH +: WIDTH];
                r_ina    <= bus.ReqInA[int'(w_win) * INBITS +: INBITS];
                r_inb    <= bus.ReqInB[int'(w_win) * INBITS +: INBITS];
                r_sel    <= bus.ReqSel[int'(w_win) * SEL_W +: SEL_W];
            end
        end
    end

    assign bus.ValidCmd = r_valid_cmd;
    assign bus.RW       = r_rw;
    assign bus.InputKey = r_key;
    assign bus.Addr     = r_addr;
    assign bus.InA      = r_ina;
    assign bus.InB      = r_inb;
    assign bus.Sel      = r_sel;
    assign bus.ReqAck   = r_ack;
    assign bus.ReqDone  = r_done;
    assign bus.GrantId  = r_grant;
    assign bus.ArbBusy  = r_arb_busy;

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Directed bench for calc_cmd_arbiter with a simple busy-for-10-cycles calculator model.
module tb_calc_cmd_arbiter;
    localparam int NREQ   = 4;
    localparam int INBITS = 8;
    localparam int WIDTH  = 8;
    localparam int WDOG   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_busy = 1'b0;
    logic [3:0] r_model_cnt;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_cmd_arbiter_if #(.NREQ(NREQ), .INBITS(INBITS), .WIDTH(WIDTH)) bus ();

    calc_cmd_arbiter #(.NREQ(NREQ), .INBITS(INBITS), .WIDTH(WIDTH), .WDOG_CYCLES(WDOG)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Calculator model: busy from the cycle after ValidCmd for 10 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst)                   r_model_cnt <= 4'd0;
        else if (bus.ValidCmd)     r_model_cnt <= 4'd10;
        else if (r_model_cnt != 0) r_model_cnt <= r_model_cnt - 4'd1;
    end
    assign bus.CalcBusy = force_busy | (r_model_cnt != 4'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] addr, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] sel, input logic rw,
                           input logic key);
        bus.ReqAddr[i*WIDTH +: WIDTH]   = addr;
        bus.ReqInA[i*INBITS +: INBITS]  = a;
        bus.ReqInB[i*INBITS +: INBITS]  = b;
        bus.ReqSel[i*4 +: 4]            = sel;
        bus.ReqRW[i]                    = rw;
        bus.ReqKey[i]                   = key;
    endtask

    // Waits for ValidCmd; since_done counts ticks from the last ReqDone (-1 if none).
    task automatic wait_cmd(input int budget, output int ticks, output int since_done,
                            output logic [3:0] done_val, output logic got);
        got = 1'b0; ticks = 0; since_done = -1; done_val = '0;
        while (!got && ticks < budget) begin
            tick();
            ticks++;
            if (bus.ReqDone != 0) begin
                since_done = 0;
                done_val   = bus.ReqDone;
            end else if (since_done >= 0) begin
                since_done++;
            end
            if (bus.ValidCmd) got = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (bus.ArbBusy && t < budget) begin
            tick();
            t++;
        end
        chk(tag, bus.ArbBusy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ticks, since, k, err_k;
        logic got, err_busy, ack1_seen, vc_seen;
        logic [3:0] dval, err_val;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        bus.ReqValid = '0; bus.ReqRW = '0; bus.ReqKey = '0;
        bus.ReqAddr = '0; bus.ReqInA = '0; bus.ReqInB = '0; bus.ReqSel = '0;

        // Reset state
        tick(); tick();
        chk("rst_arbbusy", bus.ArbBusy, 1'b0);
        chk("rst_validcmd", bus.ValidCmd, 1'b0);
        chk("rst_grantid", bus.GrantId, 2'd0);
        chk("rst_ack", bus.ReqAck, 4'd0);
        chk("rst_done", bus.ReqDone, 4'd0);
        chk("rst_err", bus.ReqErr, 4'd0);
        chk("rst_addr", bus.Addr, 8'h00);
        rst = 1'b0;
        tick();

        // Single request from requester 2
        set_req(2, 8'h05, 8'd4, 8'd4, 4'h3, 1'b1, 1'b1);
        bus.ReqValid = 4'b0100;
        wait_cmd(10, ticks, since, dval, got);
        chk("t1_got", got, 1'b1);
        chk("t1_latency", ticks, 1);
        chk("t1_addr", bus.Addr, 8'h05);
        chk("t1_ina", bus.InA, 8'd4);
        chk("t1_inb", bus.InB, 8'd4);
        chk("t1_sel", bus.Sel, 4'h3);
        chk("t1_rw", bus.RW, 1'b1);
        chk("t1_key", bus.InputKey, 1'b1);
        chk("t1_ack", bus.ReqAck, 4'b0100);
        chk("t1_grant", bus.GrantId, 2'd2);
        bus.ReqValid = '0;
        tick();
        chk("t1_valid_pulse", bus.ValidCmd, 1'b0);
        chk("t1_ack_pulse", bus.ReqAck, 4'b0000);
        ticks = 0;
        while (bus.ReqDone == 0 && ticks < 30) begin
            tick();
            ticks++;
        end
        chk("t1_done_ticks", ticks, 11);
        chk("t1_done", bus.ReqDone, 4'b0100);
        chk("t1_done_arbbusy", bus.ArbBusy, 1'b0);
        chk("t1_addr_hold", bus.Addr, 8'h05);
        tick();
        chk("t1_done_pulse", bus.ReqDone, 4'b0000);

        // All four requesting continuously from reset
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 8'(i), 8'(i + 1), 4'(i), 1'b0, 1'b0);
        bus.ReqValid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_cmd(40, ticks, since, dval, got);
            chk("t2_got", got, 1'b1);
            chk("t2_grant", bus.GrantId, 32'(exp_order[g]));
            chk("t2_addr", bus.Addr, 32'(8'h10 + 8'(exp_order[g])));
            chk("t2_ack", bus.ReqAck, 32'(4'b0001 << exp_order[g]));
            if (g > 0) begin
                chk("t2_gap_after_done", since, 1);
                chk("t2_done", dval, 32'(4'b0001 << exp_order[g-1]));
            end
        end
        bus.ReqValid = '0;
        wait_idle("t2_idle", 30);
        tick();

        // Calculator busy in IDLE blocks issue
        force_busy = 1'b1;
        bus.ReqValid = 4'b0001;
        vc_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ValidCmd) vc_seen = 1'b1;
        end
        chk("t3_blocked", vc_seen, 1'b0);
        force_busy = 1'b0;
        tick();
        chk("t3_issue", bus.ValidCmd, 1'b1);
        chk("t3_grant", bus.GrantId, 2'd0);
        chk("t3_ack", bus.ReqAck, 4'b0001);

        // Short pulse on requester 1 while requester 0 is in flight
        bus.ReqValid = '0;
        tick(); tick();
        bus.ReqValid = 4'b0010;
        tick();
        bus.ReqValid = '0;
        ack1_seen = 1'b0; vc_seen = 1'b0; dval = '0; ticks = 0;
        while (dval == 0 && ticks < 30) begin
            tick();
            ticks++;
            dval = bus.ReqDone;
            if (bus.ReqAck[1]) ack1_seen = 1'b1;
        end
        chk("t4_done", dval, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ReqAck[1]) ack1_seen = 1'b1;
            if (bus.ValidCmd) vc_seen = 1'b1;
        end
        chk("t4_no_ack1", ack1_seen, 1'b0);
        chk("t4_no_cmd", vc_seen, 1'b0);

        // Asynchronous reset mid-WAIT_DONE
        bus.ReqValid = 4'b0100;
        wait_cmd(10, ticks, since, dval, got);
        chk("t5_got", got, 1'b1);
        chk("t5_grant", bus.GrantId, 2'd2);
        bus.ReqValid = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy_before", bus.ArbBusy, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_arbbusy", bus.ArbBusy, 1'b0);
        chk("t5_rst_validcmd", bus.ValidCmd, 1'b0);
        chk("t5_rst_grantid", bus.GrantId, 2'd0);
        vc_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.ReqDone != 0) vc_seen = 1'b1;
        end
        rst = 1'b0;
        bus.ReqValid = 4'b1001;
        wait_cmd(10, ticks, since, dval, got);
        if (since >= 0) vc_seen = 1'b1;
        chk("t5_no_done", vc_seen, 1'b0);
        chk("t5_got2", got, 1'b1);
        chk("t5_first_grant", bus.GrantId, 2'd0);
        chk("t5_first_ack", bus.ReqAck, 4'b0001);
        bus.ReqValid = '0;
        wait_idle("t5_idle", 30);
        tick();

        // Calculator busy stuck high
        bus.ReqValid = 4'b0100;
        wait_cmd(10, ticks, since, dval, got);
        chk("t6_got", got, 1'b1);
        bus.ReqValid = '0;
        force_busy = 1'b1;
        err_k = 0; err_val = '0; err_busy = 1'b1;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (bus.ReqErr != 0 && err_k == 0) begin
                err_k    = k;
                err_val  = bus.ReqErr;
                err_busy = bus.ArbBusy;
            end
        end
`ifdef CALC_ARB_WATCHDOG_EN
        chk("t6_err_time", err_k, WDOG);
        chk("t6_err_val", err_val, 4'b0100);
        chk("t6_err_idle", err_busy, 1'b0);
        chk("t6_idle_after", bus.ArbBusy, 1'b0);
        force_busy = 1'b0;
`else
        chk("t6_no_err", err_k, 0);
        chk("t6_still_busy", bus.ArbBusy, 1'b1);
        force_busy = 1'b0;
        dval = '0; ticks = 0;
        while (dval == 0 && ticks < 20) begin
            tick();
            ticks++;
            dval = bus.ReqDone;
        end
        chk("t6_done_after_release", dval, 4'b0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_cmd_arbiter.md
# calc_cmd_arbiter

Round-robin command arbiter that shares one BinaryCalculator between `NREQ` requesters. It sits directly in front of the calculator's command port. It latches the winning requester's command fields and issues a single-cycle `ValidCmd`. It then tracks `CalcBusy` through completion and returns a per-requester done pulse before granting the next command.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `INBITS`, 8, operand width (matches calculator `InA`/`InB`)
- `WIDTH`, 8, address width (matches calculator `Addr`)
- `WDOG_CYCLES`, 255, watchdog limit in clock cycles; used only when `CALC_ARB_WATCHDOG_EN` is defined
- `Clk`  in  1  system clock, rising-edge
- `Reset`  in  1  asynchronous, active-high reset
- `ReqValid`  in  NREQ  per-requester command request (level)
- `ReqRW`  in  NREQ  per-requester RW bit
- `ReqKey`  in  NREQ  per-requester InputKey level
- `ReqAddr`  in  NREQ*WIDTH  flattened addresses; requester i at `[i*WIDTH +: WIDTH]`
- `ReqInA`, `ReqInB`  in  NREQ*INBITS  flattened operands
- `ReqSel`  in  NREQ*4  flattened Sel fields
- `ReqAck`  out  NREQ  one-hot, 1-cycle pulse: command accepted and fields latched
- `ReqDone`  out  NREQ  one-hot, 1-cycle pulse: calculator finished the command
- `ReqErr`  out  NREQ  one-hot, 1-cycle pulse: watchdog abort
- `ValidCmd`, `RW`, `InputKey`  out  1  to calculator
- `Addr`  out  WIDTH, `InA`/`InB`  out  INBITS, `Sel`  out  4  to calculator
- `CalcBusy`  in  1  from calculator
- `GrantId`  out  $clog2(NREQ)  index of the current/last granted requester
- `ArbBusy`  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE → ISSUE when any `ReqValid`=1 and `CalcBusy`=0. The winner is the first requester at or after `rr_ptr`, searching in wrap-around order.
  - ISSUE (1 cycle) → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when `CalcBusy`=1.
  - WAIT_DONE → IDLE when `CalcBusy`=0. In that cycle `ReqDone[GrantId]` pulses.
- On the IDLE→ISSUE edge:
  - Latch the winner's RW/Key/Addr/InA/InB/Sel into output registers.
  - Set `GrantId`.
  - Set `rr_ptr` = winner+1 mod NREQ.
- In ISSUE, `ValidCmd`=1 and `ReqAck[GrantId]`=1 for exactly one cycle.
- Latched fields hold stable on the calculator outputs from ISSUE until the return to IDLE, then keep their last value.
- Requests are sampled only in IDLE:
  - A requester deasserting `ReqValid` before its Ack is not served.
  - A requester still asserting `ReqValid` after Done is re-arbitrated with its priority rotated to the lowest level.
- If `CalcBusy`=1 while in IDLE (e.g. divider configuration), no command is issued.
- Reset, asynchronous, any state:
  - FSM returns to IDLE and `rr_ptr`=0.
  - All outputs go to 0, including `GrantId`.
  - No Done or Err pulse is produced for an aborted command.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge t → `ValidCmd`/`ReqAck` high during cycle t+1.
- `CalcBusy` falling sampled at edge t → `ReqDone` high during cycle t+1, with `ArbBusy`=0 in the same cycle.
- Minimum spacing between consecutive `ValidCmd` pulses: ISSUE + ≥1 WAIT_BUSY + ≥1 WAIT_DONE + 1 IDLE = 4 cycles.
- No back-to-back grant without passing through IDLE.

## Configuration
- `CALC_ARB_WATCHDOG_EN` defined:
  - A cycle counter runs in WAIT_BUSY and WAIT_DONE and is cleared on entry to ISSUE.
  - On reaching `WDOG_CYCLES`, `ReqErr[GrantId]` pulses 1 cycle and the FSM goes to IDLE with no `ReqDone`.
- Not defined:
  - No counter is built and `ReqErr` is tied to 0.
  - WAIT_BUSY and WAIT_DONE wait indefinitely.

## Structure
- Package `calc_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - the Sel width constant (4);
  - the watchdog counter width function.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are a found flag and the winner index.

## Test plan
- Single request: ReqValid[2]=1, ReqAddr[2]=8'h05, InA=4, InB=4. Calculator model raises busy 1 cycle after ValidCmd, holds it 10 cycles → ValidCmd 1-cycle pulse with Addr=05 and ReqAck=4'b0100. ReqDone=4'b0100 one cycle after busy falls.
- All four requesting continuously from reset → grant order 0,1,2,3,0. Each ValidCmd follows the previous ReqDone by exactly 1 cycle.
- CalcBusy=1 held 5 cycles in IDLE while ReqValid[0]=1 → no ValidCmd until the cycle after CalcBusy falls.
- ReqValid[1] pulsed 1 cycle while a command from requester 0 is in flight → requester 1 never acked.
- Reset asserted mid-WAIT_DONE → ArbBusy, ValidCmd and GrantId go to 0 immediately, with no ReqDone. The next request from requester 0 is granted first.
- With `CALC_ARB_WATCHDOG_EN` and WDOG_CYCLES=20, calculator busy stuck high → ReqErr[GrantId] pulses 20 cycles after ISSUE, then IDLE. Without the macro the FSM stays in WAIT_DONE.
